// File: rtl/mdu_seq_pkg.sv
// Shared op codes and helpers for the multiply/divide sequencer.
package mdu_seq_pkg;

  localparam int unsigned MDU_OP_W = 3;
  localparam int unsigned ALU_OP_W = 4;

  // Multiply/divide unit op codes
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;

  // Step-unit op codes, shared with the core ALU encoding
  localparam logic [ALU_OP_W-1:0] ALU_ADDU = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUBU = 4'd1;

  function automatic logic is_valid_op(input logic [MDU_OP_W-1:0] op);
    return op <= MDU_MTLO;
  endfunction

endpackage

// File: rtl/mdu_seq_alu.sv
// Add/subtract step unit; exposes the carry so the divider can use it as a no-borrow flag.
module mdu_seq_alu
  import mdu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [ALU_OP_W-1:0]   opcode,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry
);

  logic                  sub;
  logic [DATA_WIDTH-1:0] y_eff;
  logic [DATA_WIDTH:0]   sum;

  // x + y for ADDU, x + ~y + 1 for SUBU; carry=1 on SUBU means no borrow
  always_comb begin
    sub             = (opcode == ALU_SUBU);
    y_eff           = sub ? ~y : y;
    sum             = {1'b0, x} + {1'b0, y_eff} + {{DATA_WIDTH{1'b0}}, sub};
    {carry, result} = sum;
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MDU_OP_W-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  // acc_q: product upper half / partial remainder; wrk_q: multiplier / dividend->quotient
  logic [W-1:0]    acc_q, wrk_q, opnd_q, hi_q, lo_q;
  logic            is_div_q, neg_q_q, neg_r_q, busy_q, done_q;

  logic            signed_op, op_div, a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [ALU_OP_W-1:0] alu_op;
  logic [W-1:0]    alu_x, alu_res, acc_n, wrk_n;
  logic            alu_carry, ge;
  logic [2*W-1:0]  prod, prod_fix;
  logic [W-1:0]    hi_fix, lo_fix;

  mdu_seq_alu #(
    .DATA_WIDTH(W)
  ) u_step (
    .opcode(alu_op),
    .x     (alu_x),
    .y     (opnd_q),
    .result(alu_res),
    .carry (alu_carry)
  );

  // Operand magnitudes and op class at issue time
  always_comb begin
    signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    a_neg     = signed_op & a[W-1];
    b_neg     = signed_op & b[W-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // One shift-add or restoring-divide step
  always_comb begin
    alu_op = is_div_q ? ALU_SUBU : ALU_ADDU;
    alu_x  = is_div_q ? {acc_q[W-2:0], wrk_q[W-1]} : acc_q;
    // Shifted remainder is W+1 bits; its top bit alone guarantees a non-negative difference
    ge     = acc_q[W-1] | alu_carry;
    if (is_div_q) begin
      acc_n = ge ? alu_res : alu_x;
      wrk_n = {wrk_q[W-2:0], ge};
    end else if (wrk_q[0]) begin
      acc_n = {alu_carry, alu_res[W-1:1]};
      wrk_n = {alu_res[0], wrk_q[W-1:1]};
    end else begin
      acc_n = {1'b0, acc_q[W-1:1]};
      wrk_n = {acc_q[0], wrk_q[W-1:1]};
    end
  end

  // Final sign correction applied in the FIX cycle
  always_comb begin
    prod     = {acc_q, wrk_q};
    prod_fix = neg_q_q ? -prod : prod;
    if (is_div_q) begin
      hi_fix = neg_r_q ? -acc_q : acc_q;
      lo_fix = neg_q_q ? -wrk_q : wrk_q;
    end else begin
      hi_fix = prod_fix[2*W-1:W];
      lo_fix = prod_fix[W-1:0];
    end
  end

  // Sequencer FSM with registered busy/done and HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (start && !cancel) begin
            case (op)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                state_q  <= StRun;
                cnt_q    <= CW'(W - 1);
                acc_q    <= '0;
                is_div_q <= op_div;
                opnd_q   <= op_div ? b_mag : a_mag;
                wrk_q    <= op_div ? a_mag : b_mag;
                // Divide by zero keeps the natural all-ones quotient: no quotient negate
                neg_q_q  <= (a_neg ^ b_neg) & (!op_div || (b != '0));
                neg_r_q  <= (op == MDU_DIV) & a[W-1];
              end
              MDU_MTHI: hi_q <= a;
              MDU_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        StRun: begin
          if (cancel) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            busy_q <= 1'b1;
            acc_q  <= acc_n;
            wrk_q  <= wrk_n;
            if (cnt_q == '0) state_q <= StFix;
            else             cnt_q   <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!cancel) begin
            hi_q   <= hi_fix;
            lo_q   <= lo_fix;
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Report issue attempts that the sequencer drops
  always_ff @(posedge clk) begin
    if (rst_n && start && !cancel) begin
      if (state_q != StIdle) $display("mdu_seq: start ignored while busy (op=%0d)", op);
      else if (!is_valid_op(op)) $display("mdu_seq: invalid op %0d ignored", op);
    end
  end
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq (DATA_WIDTH=32).
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, cancel, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;

  int n_vec = 0;
  int n_err = 0;

  mdu_seq #(
    .DATA_WIDTH(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cancel(cancel),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start at the current negedge; returns at cycle 0 (after the start edge)
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
  endtask

  // Full operation: checks busy/done timeline over cycles 0..33 and the final HI/LO.
  // poke>0 drives a competing MULTU start on that cycle's edge.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                        input int poke);
    logic [33:0] busy_v, done_v;
    issue(o, x, y);
    busy_v[0] = busy;
    done_v[0] = done;
    for (int k = 1; k <= 33; k++) begin
      if (poke == k) begin
        start = 1'b1;
        op    = MDU_MULTU;
        a     = 32'd3;
        b     = 32'd3;
      end
      step();
      start     = 1'b0;
      busy_v[k] = busy;
      done_v[k] = done;
    end
    check({tag, ".busy_timeline"}, {30'd0, busy_v}, {30'd0, 34'h1_FFFF_FFFE});
    check({tag, ".done_timeline"}, {30'd0, done_v}, {30'd0, 34'h2_0000_0000});
    check({tag, ".hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, ".lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    logic seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    op     = '0;
    a      = '0;
    b      = '0;
    repeat (3) step();
    rst_n = 1'b1;

    check("reset.busy", {63'd0, busy}, 64'd0);
    check("reset.done", {63'd0, done}, 64'd0);
    check("reset.hi", {32'd0, hi}, 64'd0);
    check("reset.lo", {32'd0, lo}, 64'd0);

    // Preload HI/LO so reset-to-zero is observable
    issue(MDU_MTHI, 32'h1111_1111, 32'd0);
    issue(MDU_MTLO, 32'h2222_2222, 32'd0);
    check("preload.hi", {32'd0, hi}, {32'd0, 32'h1111_1111});
    check("preload.lo", {32'd0, lo}, {32'd0, 32'h2222_2222});

    // Reset mid-RUN of MULTU 5*7
    issue(MDU_MULTU, 32'd5, 32'd7);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midreset.busy", {63'd0, busy}, 64'd0);
    check("midreset.done", {63'd0, done}, 64'd0);
    check("midreset.hi", {32'd0, hi}, 64'd0);
    check("midreset.lo", {32'd0, lo}, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      seen |= done;
    end
    check("midreset.no_done", {63'd0, seen}, 64'd0);

    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("mult_minsq", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("divu_zero", MDU_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 0);
    run_op("div_zero_neg", MDU_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 0);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);

    // MTHI: immediate write, no busy/done
    issue(MDU_MTHI, 32'hCAFE_F00D, 32'd0);
    check("mthi.hi", {32'd0, hi}, {32'd0, 32'hCAFE_F00D});
    check("mthi.busy", {63'd0, busy}, 64'd0);
    check("mthi.done", {63'd0, done}, 64'd0);

    // Cancel at cycle 10 of a DIV
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (10) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel.busy", {63'd0, busy}, 64'd0);
    check("cancel.done", {63'd0, done}, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      seen |= done;
    end
    check("cancel.no_done", {63'd0, seen}, 64'd0);
    check("cancel.hi", {32'd0, hi}, {32'd0, 32'hCAFE_F00D});
    check("cancel.lo", {32'd0, lo}, {32'd0, 32'h8000_0000});

    // cancel in IDLE suppresses a simultaneous MTHI
    cancel = 1'b1;
    issue(MDU_MTHI, 32'hDEAD_BEEF, 32'd0);
    cancel = 1'b0;
    check("idle_cancel.hi", {32'd0, hi}, {32'd0, 32'hCAFE_F00D});

    // Invalid op: no state change
    issue(3'd7, 32'h5555_5555, 32'd1);
    check("badop.busy", {63'd0, busy}, 64'd0);
    step();
    check("badop.busy2", {63'd0, busy}, 64'd0);
    check("badop.hi", {32'd0, hi}, {32'd0, 32'hCAFE_F00D});

    // Start while busy must not restart the counter or change the result
    run_op("restart_ignored", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
